// File: rtl/lpc_residual_filter_if.sv
// Sample/coefficient bus between the block buffer, the LPC residual filter and the Rice encoder.
// RESIDUAL_SAT_EN adds the overflow flag to the result side.
interface lpc_residual_filter_if #(
   parameter int SAMPLE_W = 16,
   parameter int COEFF_W  = 15,
   parameter int SHIFT_W  = 5,
   parameter int RES_W    = 17,
   parameter int ORDER_W  = 6
);
   logic                       en;
   logic                       load;
   logic signed [COEFF_W-1:0]  qlp;
   logic [SHIFT_W-1:0]         shift;
   logic                       valid;
   logic signed [SAMPLE_W-1:0] sample;
   logic signed [RES_W-1:0]    residual;
   logic                       res_valid;
   logic                       warmup;
   logic [ORDER_W-1:0]         order;
`ifdef RESIDUAL_SAT_EN
   logic                       overflow;

   modport master (output en, load, qlp, shift, valid, sample,
                   input  residual, res_valid, warmup, order, overflow);
   modport slave  (input  en, load, qlp, shift, valid, sample,
                   output residual, res_valid, warmup, order, overflow);
`else
   modport master (output en, load, qlp, shift, valid, sample,
                   input  residual, res_valid, warmup, order);
   modport slave  (input  en, load, qlp, shift, valid, sample,
                   output residual, res_valid, warmup, order);
`endif
endinterface

// File: rtl/lpc_residual_filter.sv
// FLAC LPC residual filter: run-time order (burst length) and shift, 3-stage pipeline.
// Build option RESIDUAL_SAT_EN: saturate the residual instead of wrapping, and flag clipping.
//
// state   | meaning
// ST_IDLE | samples accepted; a load strobe starts a new block
// ST_LOAD | coefficient burst in progress; samples ignored
module lpc_residual_filter #(
   parameter int MAX_ORDER = 32,
   parameter int SAMPLE_W  = 16,
   parameter int COEFF_W   = 15,
   parameter int SHIFT_W   = 5,
   parameter int RES_W     = 17,
   parameter int ORDER_W   = $clog2(MAX_ORDER + 1),
   parameter int ACC_W     = SAMPLE_W + COEFF_W + $clog2(MAX_ORDER)
) (
   input logic                  clk,
   input logic                  rst_b,
   lpc_residual_filter_if.slave bus
);
   localparam int PROD_W = SAMPLE_W + COEFF_W;
   localparam int DIFF_W = ACC_W + 1;

   typedef enum logic {ST_IDLE, ST_LOAD} state_t;
   state_t state, state_nxt;
   logic   load_start, load_word, load_end, accept;

   logic signed [COEFF_W-1:0]  coeff [MAX_ORDER];
   logic signed [SAMPLE_W-1:0] hist  [MAX_ORDER+1];
   logic [ORDER_W-1:0]         cnt, order, warm_cnt;
   logic [SHIFT_W-1:0]         shift;

   logic                       s0_valid, s0_warm;
   logic signed [PROD_W-1:0]   p1_prod [MAX_ORDER];
   logic signed [SAMPLE_W-1:0] p1_sample;
   logic                       p1_valid, p1_warm;
   logic signed [ACC_W-1:0]    p2_sum, sum_c;
   logic signed [SAMPLE_W-1:0] p2_sample;
   logic                       p2_valid, p2_warm;
   logic signed [RES_W-1:0]    res_c, res_q;
   logic                       res_valid_q, warm_q;
`ifdef RESIDUAL_SAT_EN
   logic                       clip_c, ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_b) state <= ST_IDLE;
      else if (bus.en) state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_start = 1'b0;
      load_word  = 1'b0;
      load_end   = 1'b0;
      accept     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.load) begin
               state_nxt  = ST_LOAD;
               load_start = 1'b1;
            end else begin
               accept = bus.valid;
            end
         end
         ST_LOAD: begin
            if (bus.load) begin
               load_word = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
               load_end  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         for (int k = 0; k < MAX_ORDER; k++) coeff[k] <= '0;
         cnt      <= '0;
         order    <= '0;
         shift    <= '0;
         warm_cnt <= '0;
      end else if (bus.en) begin
         if (load_start) begin
            for (int k = 0; k < MAX_ORDER; k++) coeff[k] <= '0;
            coeff[0] <= bus.qlp;
            shift    <= bus.shift;
            cnt      <= ORDER_W'(1);
         end else if (load_word) begin
            // words beyond MAX_ORDER are dropped, order saturates
            if (cnt != ORDER_W'(MAX_ORDER)) begin
               for (int k = 0; k < MAX_ORDER; k++)
                  if (cnt == ORDER_W'(k)) coeff[k] <= bus.qlp;
               cnt <= cnt + ORDER_W'(1);
            end
         end else if (load_end) begin
            order    <= cnt;
            warm_cnt <= cnt;
         end else if (accept && warm_cnt != '0) begin
            warm_cnt <= warm_cnt - ORDER_W'(1);
         end
      end
   end

   always_comb begin
      sum_c = '0;
      for (int k = 0; k < MAX_ORDER; k++) sum_c = sum_c + ACC_W'(p1_prod[k]);
   end

`ifdef RESIDUAL_SAT_EN
   localparam logic signed [DIFF_W-1:0] RES_MAX = {{(DIFF_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
   localparam logic signed [DIFF_W-1:0] RES_MIN = ~RES_MAX;
   logic signed [DIFF_W-1:0] diff_c;

   always_comb begin
      diff_c = DIFF_W'(p2_sample) - DIFF_W'(p2_sum >>> shift);
      res_c  = RES_W'(diff_c);
      clip_c = 1'b0;
      if (diff_c > RES_MAX) begin
         res_c  = {1'b0, {(RES_W-1){1'b1}}};
         clip_c = 1'b1;
      end else if (diff_c < RES_MIN) begin
         res_c  = {1'b1, {(RES_W-1){1'b0}}};
         clip_c = 1'b1;
      end
   end
`else
   always_comb res_c = RES_W'(DIFF_W'(p2_sample) - DIFF_W'(p2_sum >>> shift));
`endif

   // hist[0] is the newest accepted sample; its predictor taps are hist[1..MAX_ORDER]
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         for (int k = 0; k <= MAX_ORDER; k++) hist[k] <= '0;
         for (int k = 0; k < MAX_ORDER; k++) p1_prod[k] <= '0;
         s0_valid    <= 1'b0;
         s0_warm     <= 1'b0;
         p1_sample   <= '0;
         p1_valid    <= 1'b0;
         p1_warm     <= 1'b0;
         p2_sum      <= '0;
         p2_sample   <= '0;
         p2_valid    <= 1'b0;
         p2_warm     <= 1'b0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         warm_q      <= 1'b0;
`ifdef RESIDUAL_SAT_EN
         ovf_q       <= 1'b0;
`endif
      end else if (bus.en) begin
         if (load_start) begin
            for (int k = 0; k <= MAX_ORDER; k++) hist[k] <= '0;
            s0_valid    <= 1'b0;
            p1_valid    <= 1'b0;
            p2_valid    <= 1'b0;
            res_valid_q <= 1'b0;
            warm_q      <= 1'b0;
`ifdef RESIDUAL_SAT_EN
            ovf_q       <= 1'b0;
`endif
         end else begin
            s0_valid <= accept;
            s0_warm  <= accept && (warm_cnt != '0);
            if (accept) begin
               hist[0] <= bus.sample;
               for (int k = 1; k <= MAX_ORDER; k++) hist[k] <= hist[k-1];
            end

            p1_valid  <= s0_valid;
            p1_warm   <= s0_warm;
            p1_sample <= hist[0];
            for (int k = 0; k < MAX_ORDER; k++)
               p1_prod[k] <= PROD_W'(coeff[k]) * PROD_W'(hist[k+1]);

            p2_valid  <= p1_valid;
            p2_warm   <= p1_warm;
            p2_sample <= p1_sample;
            p2_sum    <= sum_c;

            res_valid_q <= p2_valid;
            warm_q      <= p2_valid && p2_warm;
            if (p2_valid) res_q <= p2_warm ? RES_W'(p2_sample) : res_c;
`ifdef RESIDUAL_SAT_EN
            ovf_q <= p2_valid && !p2_warm && clip_c;
`endif
         end
      end
   end

   assign bus.residual  = res_q;
   assign bus.res_valid = res_valid_q;
   assign bus.warmup    = warm_q;
   assign bus.order     = order;
`ifdef RESIDUAL_SAT_EN
   assign bus.overflow  = ovf_q;
`endif
endmodule

// File: tb/tb_lpc_residual_filter.sv
// Bench for lpc_residual_filter: directed vector table, hand sequences and random traffic
// checked every edge against an arithmetic model of the filter.
module tb_lpc_residual_filter;
   localparam int MAX_ORDER = 32;
   localparam int SAMPLE_W  = 16;
   localparam int COEFF_W   = 15;
   localparam int SHIFT_W   = 5;
   localparam int RES_W     = 17;
   localparam int ORDER_W   = $clog2(MAX_ORDER + 1);

   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   lpc_residual_filter_if #(.SAMPLE_W(SAMPLE_W), .COEFF_W(COEFF_W), .SHIFT_W(SHIFT_W),
                            .RES_W(RES_W), .ORDER_W(ORDER_W)) bus ();

   lpc_residual_filter #(.MAX_ORDER(MAX_ORDER), .SAMPLE_W(SAMPLE_W), .COEFF_W(COEFF_W),
                         .SHIFT_W(SHIFT_W), .RES_W(RES_W)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   typedef struct { longint res; bit warm; bit ovf; int due; } exp_t;
   typedef struct { longint res; bit warm; int edge_idx; } cap_t;
   typedef struct { int n_coef; int coef[4]; int shift; int n_smp; int smp[5];
                    int exp_res[5]; int n_warm; int exp_order; } vec_t;

   int     n_pass = 0;
   int     n_checks = 0;
   int     n_edge = 0;
   exp_t   exp_q[$];
   cap_t   cap_q[$];
   vec_t   vecs[5];

   longint m_coeff[$];
   longint m_hist[$];
   int     m_shift = 0, m_warm = 0, m_order = 0;
   bit     m_loading = 0;
   bit     e_valid = 0, e_warm = 0, e_ovf = 0;
   longint e_res = 0;

   function automatic void chk(string name, longint got, longint want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (enabled edge %0d)", name, got, want, n_edge);
   endfunction

   function automatic void predict(input longint smp, output longint res, output bit ovf);
      longint pred, d, q, diff, hi, lo;
      pred = 0;
      for (int k = 0; k < m_coeff.size(); k++)
         if (k < m_hist.size()) pred += m_coeff[k] * m_hist[k];
      d = longint'(1) << m_shift;
      q = pred / d;
      if ((pred % d) != 0 && pred < 0) q = q - 1;
      diff = smp - q;
      hi = (longint'(1) << (RES_W - 1)) - 1;
      lo = -hi - 1;
      ovf = 1'b0;
`ifdef RESIDUAL_SAT_EN
      if (diff > hi) begin res = hi; ovf = 1'b1; end
      else if (diff < lo) begin res = lo; ovf = 1'b1; end
      else res = diff;
`else
      res = diff & ((longint'(1) << RES_W) - 1);
      if (res > hi) res = res - (longint'(1) << RES_W);
`endif
   endfunction

   function automatic void model_reset();
      m_coeff.delete(); m_hist.delete(); exp_q.delete();
      m_shift = 0; m_warm = 0; m_order = 0; m_loading = 0;
      e_valid = 0; e_warm = 0; e_ovf = 0; e_res = 0;
   endfunction

   function automatic void model_step(bit ld, longint qlp, int sh, bit vl, longint smp);
      exp_t   e;
      longint r;
      bit     o;
      if (m_loading) begin
         if (ld) begin
            if (m_coeff.size() < MAX_ORDER) m_coeff.push_back(qlp);
         end else begin
            m_loading = 0; m_order = m_coeff.size(); m_warm = m_order;
         end
      end else if (ld) begin
         m_loading = 1; m_coeff.delete(); m_coeff.push_back(qlp);
         m_hist.delete(); m_shift = sh; exp_q.delete();
      end else if (vl) begin
         if (m_warm > 0) begin
            r = smp; o = 1'b0; e.warm = 1'b1; m_warm--;
         end else begin
            predict(smp, r, o); e.warm = 1'b0;
         end
         e.res = r; e.ovf = o; e.due = n_edge + 3;
         exp_q.push_back(e);
         m_hist.push_front(smp);
         if (m_hist.size() > MAX_ORDER) void'(m_hist.pop_back());
      end
      if (exp_q.size() > 0 && exp_q[0].due == n_edge) begin
         e = exp_q.pop_front();
         e_valid = 1; e_res = e.res; e_warm = e.warm; e_ovf = e.ovf;
      end else begin
         e_valid = 0; e_warm = 0; e_ovf = 0;
      end
   endfunction

   task automatic tick();
      bit     en_e, rst_e, ld, vl;
      longint qlp, smp;
      int     sh;
      cap_t   c;
      @(posedge clk);
      rst_e = rst_b; en_e = bus.en; ld = bus.load; vl = bus.valid;
      qlp = longint'(bus.qlp); smp = longint'(bus.sample); sh = int'(bus.shift);
      if (!rst_e) model_reset();
      else if (en_e) begin
         n_edge++;
         model_step(ld, qlp, sh, vl, smp);
      end
      #1;
      chk("valid", longint'(bus.res_valid), longint'(e_valid));
      chk("warmup", longint'(bus.warmup), longint'(e_warm));
      chk("order", longint'(bus.order), longint'(m_order));
      if (e_valid || !en_e || !rst_e) chk("residual", longint'(bus.residual), e_res);
`ifdef RESIDUAL_SAT_EN
      chk("overflow", longint'(bus.overflow), longint'(e_ovf));
`endif
      if (rst_e && en_e && bus.res_valid) begin
         c.res = longint'(bus.residual); c.warm = bus.warmup; c.edge_idx = n_edge;
         cap_q.push_back(c);
      end
   endtask

   task automatic drive(bit en, bit ld, int qlp, int sh, bit vl, int smp);
      bus.en = en; bus.load = ld; bus.qlp = COEFF_W'(qlp); bus.shift = SHIFT_W'(sh);
      bus.valid = vl; bus.sample = SAMPLE_W'(smp);
      tick();
   endtask

   task automatic load_burst(input int coefs[$], input int sh);
      foreach (coefs[i]) drive(1'b1, 1'b1, coefs[i], sh, 1'b0, 0);
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
   endtask

   task automatic idle(int n);
      repeat (n) drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
   endtask

   initial begin
      int cq[$];
      int first_acc, nc, sh;

      vecs[0].n_coef = 1; vecs[0].coef = '{1, 0, 0, 0}; vecs[0].shift = 0; vecs[0].n_smp = 3;
      vecs[0].smp = '{10, 13, 20, 0, 0}; vecs[0].exp_res = '{10, 3, 7, 0, 0};
      vecs[0].n_warm = 1; vecs[0].exp_order = 1;
      vecs[1].n_coef = 2; vecs[1].coef = '{2, -1, 0, 0}; vecs[1].shift = 0; vecs[1].n_smp = 5;
      vecs[1].smp = '{1, 4, 9, 16, 25}; vecs[1].exp_res = '{1, 4, 2, 2, 2};
      vecs[1].n_warm = 2; vecs[1].exp_order = 2;
      vecs[2].n_coef = 1; vecs[2].coef = '{3, 0, 0, 0}; vecs[2].shift = 1; vecs[2].n_smp = 2;
      vecs[2].smp = '{10, 11, 0, 0, 0}; vecs[2].exp_res = '{10, -4, 0, 0, 0};
      vecs[2].n_warm = 1; vecs[2].exp_order = 1;
      vecs[3].n_coef = 1; vecs[3].coef = '{-3, 0, 0, 0}; vecs[3].shift = 1; vecs[3].n_smp = 2;
      vecs[3].smp = '{5, 0, 0, 0, 0}; vecs[3].exp_res = '{5, 8, 0, 0, 0};
      vecs[3].n_warm = 1; vecs[3].exp_order = 1;
      vecs[4].n_coef = 1; vecs[4].coef = '{-16384, 0, 0, 0}; vecs[4].shift = 0; vecs[4].n_smp = 2;
      vecs[4].smp = '{32767, 32767, 0, 0, 0};
`ifdef RESIDUAL_SAT_EN
      vecs[4].exp_res = '{32767, 65535, 0, 0, 0};
`else
      vecs[4].exp_res = '{32767, 16383, 0, 0, 0};
`endif
      vecs[4].n_warm = 1; vecs[4].exp_order = 1;

      rst_b = 1'b0;
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 5);
      rst_b = 1'b1;

      for (int i = 0; i < 5; i++) begin
         cq.delete();
         for (int j = 0; j < vecs[i].n_coef; j++) cq.push_back(vecs[i].coef[j]);
         load_burst(cq, vecs[i].shift);
         cap_q.delete();
         first_acc = n_edge + 1;
         for (int j = 0; j < vecs[i].n_smp; j++) drive(1'b1, 1'b0, 0, 0, 1'b1, vecs[i].smp[j]);
         idle(5);
         chk("vec_count", cap_q.size(), vecs[i].n_smp);
         for (int j = 0; j < cap_q.size() && j < vecs[i].n_smp; j++) begin
            chk("vec_res", cap_q[j].res, vecs[i].exp_res[j]);
            chk("vec_warm", longint'(cap_q[j].warm), longint'(j < vecs[i].n_warm));
         end
         if (cap_q.size() > 0) chk("vec_latency", cap_q[0].edge_idx - first_acc, 3);
         chk("vec_order", longint'(bus.order), vecs[i].exp_order);
      end

      // enable dropped for 4 cycles while samples are in flight
      cq.delete(); cq.push_back(1);
      load_burst(cq, 0);
      cap_q.delete();
      for (int j = 0; j < 12; j++) begin
         if (j == 5) repeat (4) drive(1'b0, 1'b0, 0, 0, 1'b1, 12345);
         drive(1'b1, 1'b0, 0, 0, 1'b1, j * 7 - 30);
      end
      idle(5);
      chk("freeze_count", cap_q.size(), 12);
      for (int j = 0; j < cap_q.size() && j < 12; j++)
         chk("freeze_res", cap_q[j].res, (j == 0) ? -30 : 7);

      // load and sample in the same cycle: the sample must vanish
      cap_q.delete();
      drive(1'b1, 1'b1, 1, 0, 1'b1, 999);
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
      drive(1'b1, 1'b0, 0, 0, 1'b1, 50);
      drive(1'b1, 1'b0, 0, 0, 1'b1, 60);
      idle(5);
      chk("drop_count", cap_q.size(), 2);
      if (cap_q.size() == 2) begin
         chk("drop_res0", cap_q[0].res, 50);
         chk("drop_res1", cap_q[1].res, 10);
      end

      // synchronous reset with samples in flight
      cq.delete(); cq.push_back(2); cq.push_back(-1);
      load_burst(cq, 0);
      for (int j = 0; j < 4; j++) drive(1'b1, 1'b0, 0, 0, 1'b1, 100 + j);
      rst_b = 1'b0;
      drive(1'b1, 1'b0, 0, 0, 1'b1, 77);
      rst_b = 1'b1;
      chk("rst_valid", longint'(bus.res_valid), 0);
      chk("rst_order", longint'(bus.order), 0);
      cap_q.delete();
      drive(1'b1, 1'b0, 0, 0, 1'b1, 7);
      drive(1'b1, 1'b0, 0, 0, 1'b1, -3);
      idle(5);
      chk("post_rst_count", cap_q.size(), 2);
      if (cap_q.size() == 2) begin
         chk("post_rst_res0", cap_q[0].res, 7);
         chk("post_rst_res1", cap_q[1].res, -3);
         chk("post_rst_warm", longint'(cap_q[0].warm) + longint'(cap_q[1].warm), 0);
      end

      // overlong burst saturates the order
      cq.delete();
      for (int j = 0; j < 40; j++) cq.push_back(int'($urandom_range(0, 32767)) - 16384);
      load_burst(cq, 3);
      chk("order_sat", longint'(bus.order), MAX_ORDER);
      for (int j = 0; j < 45; j++) drive(1'b1, 1'b0, 0, 0, 1'b1, int'($urandom_range(0, 65535)) - 32768);

      // random blocks, gapped enables/valids, bursts cutting into live pipelines
      for (int b = 0; b < 8; b++) begin
         nc = $urandom_range(1, 36);
         sh = $urandom_range(0, 16);
         for (int j = 0; j < nc; j++)
            drive($urandom_range(0, 4) != 0, 1'b1, int'($urandom_range(0, 32767)) - 16384,
                  (j == 0) ? sh : int'($urandom_range(0, 31)), $urandom_range(0, 1) != 0, 0);
         for (int j = 0; j < 80; j++)
            drive($urandom_range(0, 5) != 0, 1'b0, 0, 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 65535)) - 32768);
      end
      idle(6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
